// File: rtl/spare_remap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spare_remap_pkg
//  Purpose  : Shared width-derivation helpers and the FSM state encoding for
//             the spare-column remapper.
//  Contents : col_w()   - logical column index width
//             spare_w() - spare index width (never narrower than 1)
//             phys_w()  - physical column width (one extra bit addresses the
//                         spare region above NUM_COLS)
//             state_t   - ACTIVE / DRAIN / LOAD
//  Revision : 1.0 - initial release
// ============================================================================
package spare_remap_pkg;

    function automatic int col_w(input int num_cols);
        return (num_cols > 1) ? $clog2(num_cols) : 1;
    endfunction

    function automatic int spare_w(input int num_spares);
        return (num_spares > 1) ? $clog2(num_spares) : 1;
    endfunction

    function automatic int phys_w(input int num_cols);
        return col_w(num_cols) + 1;
    endfunction

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        LOAD   = 2'd2
    } state_t;

endpackage : spare_remap_pkg
`default_nettype wire

// File: rtl/spare_col_remapper_if.sv
`default_nettype none
// ============================================================================
//  Module   : spare_col_remapper_if
//  Purpose  : Lookup request/response bundle between the array access path
//             (master) and the remapper (slave).
//  Signals  : req_valid/req_ready/req_col             - lookup request
//             rsp_valid/rsp_ready/rsp_phys/
//             rsp_is_spare/rsp_spare_idx               - lookup result
//  Revision : 1.0 - initial release
// ============================================================================
interface spare_col_remapper_if #(
    parameter int NUM_COLS   = 256,
    parameter int NUM_SPARES = 8
) ();
    import spare_remap_pkg::*;

    localparam int COL_W   = col_w(NUM_COLS);
    localparam int SPARE_W = spare_w(NUM_SPARES);
    localparam int PHYS_W  = phys_w(NUM_COLS);

    logic               req_valid;
    logic               req_ready;
    logic [COL_W-1:0]   req_col;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [PHYS_W-1:0]  rsp_phys;
    logic               rsp_is_spare;
    logic [SPARE_W-1:0] rsp_spare_idx;

    modport master (
        output req_valid, req_col, rsp_ready,
        input  req_ready, rsp_valid, rsp_phys, rsp_is_spare, rsp_spare_idx
    );

    modport slave (
        input  req_valid, req_col, rsp_ready,
        output req_ready, rsp_valid, rsp_phys, rsp_is_spare, rsp_spare_idx
    );

endinterface : spare_col_remapper_if
`default_nettype wire

// File: rtl/spare_col_remapper_match_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : spare_match_encoder
//  Purpose  : Combinational parallel compare of one column against every
//             valid remap entry, followed by a lowest-index priority encode.
//  Ports    : col       in  column to look up
//             entries   in  faulty column held by each spare
//             entry_vld in  per-spare valid bits
//             hit       out at least one valid entry matches
//             idx       out lowest matching spare index (0 when no hit)
//  Revision : 1.0 - initial release
// ============================================================================
module spare_match_encoder
    import spare_remap_pkg::*;
#(
    parameter  int NUM_COLS   = 256,
    parameter  int NUM_SPARES = 8,
    localparam int COL_W      = col_w(NUM_COLS),
    localparam int SPARE_W    = spare_w(NUM_SPARES)
) (
    input  logic [COL_W-1:0]                  col,
    input  logic [NUM_SPARES-1:0][COL_W-1:0]  entries,
    input  logic [NUM_SPARES-1:0]             entry_vld,
    output logic                              hit,
    output logic [SPARE_W-1:0]                idx
);

    logic [NUM_SPARES-1:0] w_match;

    generate
        for (genvar g = 0; g < NUM_SPARES; g++) begin : g_cmp
            assign w_match[g] = entry_vld[g] && (entries[g] == col);
        end
    endgenerate

    // Scan from the top down so the last assignment is the lowest match.
    always_comb begin
        hit = |w_match;
        idx = '0;
        for (int i = NUM_SPARES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                idx = SPARE_W'(i);
            end
        end
    end

endmodule : spare_match_encoder
`default_nettype wire

// File: rtl/spare_col_remapper.sv
`default_nettype none
// ============================================================================
//  Module   : spare_col_remapper
//  Purpose  : Runtime spare-column remap. A table of faulty columns (one per
//             spare) is loaded serially; every logical column lookup is then
//             translated to a physical column, faulty ones being steered to
//             NUM_COLS + spare index. Two-stage stall-all pipeline.
//  Ports    : clk, rst_n                 clock, async active-low reset
//             cfg_start                  request a table reload
//             cfg_valid/cfg_ready/
//             cfg_col/cfg_last           serial table load
//             bus (slave)                lookup request/response handshake
//             spares_used                number of entries loaded
//             dup_err, ovf_err           sticky load errors
//             redirect_count             (only with SPARE_COL_REMAPPER_STATS_EN)
//                                        saturating count of redirected
//                                        responses, cleared on reload
//  Options  : SPARE_COL_REMAPPER_STATS_EN - adds redirect_count
//  Revision : 1.0 - initial release
// ============================================================================
module spare_col_remapper
    import spare_remap_pkg::*;
#(
    parameter  int NUM_COLS   = 256,
    parameter  int NUM_SPARES = 8,
    localparam int COL_W      = col_w(NUM_COLS),
    localparam int SPARE_W    = spare_w(NUM_SPARES),
    localparam int PHYS_W     = phys_w(NUM_COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [COL_W-1:0]     cfg_col,
    input  logic                 cfg_last,
    spare_col_remapper_if.slave  bus,
    output logic [SPARE_W:0]     spares_used,
    output logic                 dup_err,
`ifdef SPARE_COL_REMAPPER_STATS_EN
    output logic [31:0]          redirect_count,
`endif
    output logic                 ovf_err
);

    localparam logic [SPARE_W:0]  C_MAX_COUNT = (SPARE_W+1)'(NUM_SPARES);
    localparam logic [PHYS_W-1:0] C_SPARE_BASE = PHYS_W'(NUM_COLS);

    state_t                           r_state;
    logic [NUM_SPARES-1:0][COL_W-1:0] r_entry;
    logic [NUM_SPARES-1:0]            r_entry_vld;
    logic [SPARE_W:0]                 r_count;
    logic                             r_dup_err;
    logic                             r_ovf_err;

    logic                             r_s1_valid;
    logic [COL_W-1:0]                 r_s1_col;
    logic                             r_rsp_valid;
    logic [PHYS_W-1:0]                r_rsp_phys;
    logic                             r_rsp_is_spare;
    logic [SPARE_W-1:0]               r_rsp_idx;

    logic                             w_advance;
    logic                             w_req_ready;
    logic                             w_req_fire;
    logic                             w_room;
    logic [SPARE_W-1:0]               w_wr_idx;
    logic                             w_dup;
    logic                             w_hit;
    logic [SPARE_W-1:0]               w_idx;

    // Whole pipeline moves together; a stalled response freezes stage 1 too.
    assign w_advance   = !r_rsp_valid || bus.rsp_ready;
    assign w_req_ready = (r_state == ACTIVE) && w_advance;
    assign w_req_fire  = bus.req_valid && w_req_ready;
    assign w_room      = (r_count < C_MAX_COUNT);
    assign w_wr_idx    = r_count[SPARE_W-1:0];

    // Duplicate check against entries already valid before this write.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < NUM_SPARES; i++) begin
            if (r_entry_vld[i] && (r_entry[i] == cfg_col)) begin
                w_dup = 1'b1;
            end
        end
    end

    spare_match_encoder #(
        .NUM_COLS   (NUM_COLS),
        .NUM_SPARES (NUM_SPARES)
    ) u_lookup (
        .col       (r_s1_col),
        .entries   (r_entry),
        .entry_vld (r_entry_vld),
        .hit       (w_hit),
        .idx       (w_idx)
    );

    // ------------------------------------------------------------------
    // Control FSM and remap table. The table is only rewritten in LOAD,
    // which is entered solely from an empty pipeline, so in-flight
    // lookups always see the table they were accepted against.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACTIVE;
            r_entry     <= '0;
            r_entry_vld <= '0;
            r_count     <= '0;
            r_dup_err   <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            case (r_state)
                ACTIVE: begin
                    if (cfg_start) begin
                        r_state   <= DRAIN;
                        r_dup_err <= 1'b0;
                        r_ovf_err <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!r_s1_valid && !r_rsp_valid) begin
                        r_state     <= LOAD;
                        r_entry_vld <= '0;
                        r_count     <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        if (w_room) begin
                            r_entry[w_wr_idx]     <= cfg_col;
                            r_entry_vld[w_wr_idx] <= 1'b1;
                            r_count               <= r_count + 1'b1;
                            if (w_dup) begin
                                r_dup_err <= 1'b1;
                            end
                        end else begin
                            r_ovf_err <= 1'b1;
                        end
                        if (cfg_last) begin
                            r_state <= ACTIVE;
                        end
                    end
                end
                default: r_state <= ACTIVE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Lookup pipeline: stage 1 holds the accepted column, stage 2 holds
    // the encoded result that is presented on the response port.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_col       <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_phys     <= '0;
            r_rsp_is_spare <= 1'b0;
            r_rsp_idx      <= '0;
        end else if (w_advance) begin
            r_s1_valid     <= w_req_fire;
            r_s1_col       <= bus.req_col;
            r_rsp_valid    <= r_s1_valid;
            r_rsp_phys     <= w_hit ? (C_SPARE_BASE + PHYS_W'(w_idx))
                                    : {1'b0, r_s1_col};
            r_rsp_is_spare <= w_hit;
            r_rsp_idx      <= w_hit ? w_idx : '0;
        end
    end

`ifdef SPARE_COL_REMAPPER_STATS_EN
    logic [31:0] r_redirect_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_count <= '0;
        end else if (r_state == ACTIVE && cfg_start) begin
            r_redirect_count <= '0;
        end else if (r_rsp_valid && bus.rsp_ready && r_rsp_is_spare &&
                     (r_redirect_count != 32'hFFFF_FFFF)) begin
            r_redirect_count <= r_redirect_count + 32'd1;
        end
    end

    assign redirect_count = r_redirect_count;
`endif

    assign cfg_ready         = (r_state == LOAD);
    assign bus.req_ready     = w_req_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_phys      = r_rsp_phys;
    assign bus.rsp_is_spare  = r_rsp_is_spare;
    assign bus.rsp_spare_idx = r_rsp_idx;
    assign spares_used       = r_count;
    assign dup_err           = r_dup_err;
    assign ovf_err           = r_ovf_err;

endmodule : spare_col_remapper
`default_nettype wire
